leds_responder: RTL and testbench

Memory-mapped LED peripheral answering femtorv32 bus cycles in the 0x4xxxxxxx region whenever its select input (driven by the SoC address decoder's LED select) is high. It holds an LED data register with set/clear/toggle aliases plus a hardware blink engine (programmable-period prescaler and blink mask). Reads return register contents one cycle after the strobe. Sits between the CPU bus and the board LED pins.

---
 rtl/leds_responder_if.sv | 22 ++
 rtl/leds_responder.sv | 113 +++++++++++
 tb/tb_leds_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/leds_responder_if.sv
// femtorv32-style memory bus as seen by the LED peripheral.
// The master side is the CPU/decoder; the slave side is the responder.
interface leds_responder_if;
    logic        sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  sel, mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

// File: rtl/leds_responder.sv
// Memory-mapped LED peripheral: DATA register with set/clear/toggle
// aliases, plus a blink engine that periodically inverts the BMASK bits.
// Zero wait states; reads return registered data one cycle after the strobe.
module leds_responder #(
    parameter int NUM_LEDS = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    leds_responder_if.slave     bus,
    output logic [NUM_LEDS-1:0] leds
);
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_TGL    = 3'd3;
    localparam logic [2:0] OFF_PERIOD = 3'd4;
    localparam logic [2:0] OFF_BMASK  = 3'd5;

    logic [NUM_LEDS-1:0] data_q;
    logic [NUM_LEDS-1:0] bmask_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_q;
    logic [31:0]         rdata_q;

    logic                wr_en;
    logic                rd_en;
    logic [2:0]          off;
    logic [31:0]         byte_en;
    logic [31:0]         wval;
    logic [NUM_LEDS-1:0] led_en;
    logic [NUM_LEDS-1:0] led_w;
    logic [PERIOD_W-1:0] per_en;
    logic [PERIOD_W-1:0] per_w;
    logic                period_wr;
    logic [31:0]         rd_val;
    logic                unused_bits;

    assign wr_en     = bus.sel & (|bus.mem_wmask);
    assign rd_en     = bus.sel & bus.mem_rstrb;
    assign off       = bus.mem_addr[4:2];
    assign byte_en   = {{8{bus.mem_wmask[3]}}, {8{bus.mem_wmask[2]}},
                        {8{bus.mem_wmask[1]}}, {8{bus.mem_wmask[0]}}};
    // Disabled bytes read as zero, which is exactly what SET/CLR/TGL need.
    assign wval      = bus.mem_wdata & byte_en;
    assign led_en    = byte_en[NUM_LEDS-1:0];
    assign led_w     = wval[NUM_LEDS-1:0];
    assign per_en    = byte_en[PERIOD_W-1:0];
    assign per_w     = wval[PERIOD_W-1:0];
    assign period_wr = wr_en && (off == OFF_PERIOD);

    // Address bits outside [4:2] and write bits above the register widths are don't-care.
    assign unused_bits = ^{bus.mem_addr[31:5], bus.mem_addr[1:0], wval};

    assign bus.mem_rbusy = 1'b0;
    assign bus.mem_wbusy = 1'b0;
    assign bus.mem_rdata = rdata_q;

    // Register file writes; DATA/PERIOD/BMASK merge enabled bytes only.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            bmask_q  <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            case (off)
                OFF_DATA:   data_q   <= (data_q & ~led_en) | led_w;
                OFF_SET:    data_q   <= data_q | led_w;
                OFF_CLR:    data_q   <= data_q & ~led_w;
                OFF_TGL:    data_q   <= data_q ^ led_w;
                OFF_PERIOD: period_q <= (period_q & ~per_en) | per_w;
                OFF_BMASK:  bmask_q  <= (bmask_q & ~led_en) | led_w;
                default:    ;
            endcase
        end
    end

    // Blink prescaler: phase flips every PERIOD cycles; a PERIOD write restarts it.
    always_ff @(posedge clk) begin
        if (reset || period_wr || (period_q == '0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + PERIOD_W'(1);
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_DATA:   rd_val = 32'(data_q);
            OFF_PERIOD: rd_val = 32'(period_q);
            OFF_BMASK:  rd_val = 32'(bmask_q);
            default:    rd_val = '0;
        endcase
    end

    // Read data register: loads on an accepted read, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rd_val;
        end
    end

    assign leds = data_q ^ (bmask_q & {NUM_LEDS{phase_q}});
endmodule

// File: tb/tb_leds_responder.sv
// Directed bench for leds_responder: a register-level model predicts leds and
// mem_rdata every cycle, and hand-computed literals pin key points of the model.
module tb_leds_responder;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] leds;

    leds_responder_if bus ();

    leds_responder #(.NUM_LEDS(8), .PERIOD_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Phase is derived from how many edges have elapsed since the blink was
    // (re)started, rather than from a prescaler counter.
    logic [31:0] m_data = '0, m_bmask = '0, m_period = '0, m_rdata = '0;
    int unsigned m_since = 0;

    function automatic logic [31:0] bytes_of(input logic [3:0] m);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r |= 32'hFF << (8 * i);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int o);
        case (o)
            0: return m_data;
            4: return m_period;
            5: return m_bmask;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_leds();
        bit ph;
        ph = (m_period != 0) && (((m_since / m_period) % 2) == 1);
        return (m_data ^ (ph ? m_bmask : 32'h0)) & 32'hFF;
    endfunction

    always @(posedge clk) begin
        int o;
        logic [31:0] be, w;
        o  = int'(bus.mem_addr[4:2]);
        be = bytes_of(bus.mem_wmask);
        w  = bus.mem_wdata & be;
        if (reset) begin
            m_data <= '0; m_bmask <= '0; m_period <= '0; m_rdata <= '0; m_since <= 0;
        end else begin
            if (bus.sel && bus.mem_rstrb) m_rdata <= model_read(o);
            if (bus.sel && bus.mem_wmask != 0) begin
                case (o)
                    0: m_data   <= ((m_data & ~be) | w) & 32'hFF;
                    1: m_data   <= (m_data | w) & 32'hFF;
                    2: m_data   <= m_data & ~w & 32'hFF;
                    3: m_data   <= (m_data ^ w) & 32'hFF;
                    4: m_period <= ((m_period & ~be) | w) & 32'h00FF_FFFF;
                    5: m_bmask  <= ((m_bmask & ~be) | w) & 32'hFF;
                    default: ;
                endcase
            end
            m_since <= (bus.sel && bus.mem_wmask != 0 && o == 4) ? 0 : m_since + 1;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("leds", 32'(leds), model_leds());
            chk("rdata", bus.mem_rdata, m_rdata);
            chk("busy", {30'h0, bus.mem_rbusy, bus.mem_wbusy}, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_bus();
        bus.sel = 1'b0; bus.mem_wmask = 4'h0; bus.mem_rstrb = 1'b0;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    endtask

    task automatic acc(input int o, input logic [31:0] wd, input logic [3:0] wm,
                       input logic rs, input logic s);
        bus.sel = s; bus.mem_addr = 32'h4000_0000 | (32'(o) << 2);
        bus.mem_wdata = wd; bus.mem_wmask = wm; bus.mem_rstrb = rs;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wr(input int o, input logic [31:0] wd, input logic [3:0] wm = 4'hF);
        acc(o, wd, wm, 1'b0, 1'b1);
    endtask

    task automatic rd(input int o);
        acc(o, 32'h0, 4'h0, 1'b1, 1'b1);
    endtask

    // Reset with a concurrent full write to DATA, which must lose.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        bus.sel = 1'b1; bus.mem_addr = 32'h4000_0000; bus.mem_wdata = 32'hFFFF_FFFF;
        bus.mem_wmask = 4'hF; bus.mem_rstrb = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        idle_bus();
    endtask

    logic [7:0] exp_blink [0:11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h03,
                                     8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        idle_bus();
        do_reset(2);
        chk_en = 1'b1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        for (int o = 0; o < 8; o++) begin
            rd(o);
            chk("rst_reg", bus.mem_rdata, 32'h0);
        end

        // DATA and its aliases
        wr(0, 32'hA5); chk("data", 32'(leds), 32'hA5);
        wr(1, 32'h0F); chk("set",  32'(leds), 32'hAF);
        wr(2, 32'h81); chk("clr",  32'(leds), 32'h2E);
        wr(3, 32'hFF); chk("tgl",  32'(leds), 32'hD1);
        rd(1);         chk("rd_set", bus.mem_rdata, 32'h0);
        wr(0, 32'h0000_00FF, 4'b0010); chk("data_bytemask", 32'(leds), 32'hD1);
        wr(1, 32'h0000_00FF, 4'b0010); chk("set_bytemask",  32'(leds), 32'hD1);

        // Byte-masked PERIOD write from reset, and sel=0 writes ignored
        do_reset(1);
        wr(4, 32'h0012_3456, 4'b0010);
        rd(4); chk("period_bytemask", bus.mem_rdata, 32'h0000_3400);
        acc(0, 32'h77, 4'hF, 1'b0, 1'b0);
        chk("nosel_write", 32'(leds), 32'h0);
        acc(4, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("nosel_read_hold", bus.mem_rdata, 32'h0000_3400);
        rd(0); chk("nosel_data", bus.mem_rdata, 32'h0);

        // Blink with PERIOD=4
        wr(0, 32'h00); wr(5, 32'h03); wr(4, 32'h4);
        chk("blink_t0", 32'(leds), 32'(exp_blink[0]));
        for (int t = 1; t < 12; t++) begin
            @(negedge clk);
            chk("blink", 32'(leds), 32'(exp_blink[t]));
        end
        repeat (2) @(negedge clk);
        wr(4, 32'h0); chk("blink_off", 32'(leds), 32'h0);
        repeat (6) @(negedge clk);
        chk("blink_off_hold", 32'(leds), 32'h0);

        // PERIOD=1 toggles every cycle
        wr(4, 32'h1);
        @(negedge clk); chk("p1_a", 32'(leds), 32'h03);
        @(negedge clk); chk("p1_b", 32'(leds), 32'h00);
        wr(4, 32'h0);

        // Read latency, unmapped offsets, width truncation, read-during-write
        wr(5, 32'h3C);
        rd(5); chk("rd_bmask", bus.mem_rdata, 32'h3C);
        repeat (3) @(negedge clk);
        chk("rd_hold", bus.mem_rdata, 32'h3C);
        rd(6); chk("rd_unmapped", bus.mem_rdata, 32'h0);
        wr(7, 32'hFF); chk("wr_unmapped", 32'(leds), 32'h0);
        wr(5, 32'hFFFF_FF3C); rd(5); chk("bmask_trunc", bus.mem_rdata, 32'h3C);
        wr(4, 32'hFFFF_FFFF); rd(4); chk("period_trunc", bus.mem_rdata, 32'h00FF_FFFF);
        wr(4, 32'h0);
        wr(0, 32'h55);
        acc(0, 32'hAA, 4'hF, 1'b1, 1'b1);
        chk("rw_old", bus.mem_rdata, 32'h55);
        chk("rw_new", 32'(leds), 32'hAA);
        for (int o = 0; o < 6; o++) rd(o);

        // Reset in the middle of a blink
        wr(0, 32'h00); wr(5, 32'hFF); wr(4, 32'h3);
        repeat (3) @(negedge clk);
        chk("mid_phase1", 32'(leds), 32'hFF);
        do_reset(1);
        chk("mid_rst_leds", 32'(leds), 32'h0);
        rd(4); chk("mid_rst_period", bus.mem_rdata, 32'h0);
        repeat (5) @(negedge clk);
        chk("mid_rst_quiet", 32'(leds), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
